// File: rtl/inst_loader.sv
// Instruction loader: streams a host program into instruction SRAM, then
// releases the BNN controller and hands it the SRAM control port.
module inst_loader #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        host_valid,
  input  logic [15:0] host_data,
  input  logic        host_last,
  output logic        host_ready,
  input  logic [12:0] ctrl_isram,
  output logic [12:0] isram_ctrl,
  output logic [15:0] isram_din,
  output logic        core_rst,
  output logic        load_done,
  output logic        overflow,
  output logic [11:0] word_count,
  output logic [15:0] checksum
);

  localparam logic [12:0]     CTRL_OFF = 13'h1800;
  localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_ERR} state_t;

  state_t          r_state;
  logic [ADDR_W:0] r_wp;
  logic            r_drain;
  logic [12:0]     r_isram_ctrl;
  logic [15:0]     r_isram_din;
  logic            r_core_rst;
  logic            r_load_done;
  logic            r_overflow;
  logic [11:0]     r_word_count;
  logic [15:0]     r_checksum;

  logic w_full;
  logic w_hs;

  assign w_full     = (r_wp == DEPTH_W);
  // The drain cycle after the last word keeps the final write on the SRAM port.
  assign host_ready = (r_state == S_LOAD) && !r_drain && !w_full;
  assign w_hs       = host_valid && host_ready;

  // The controller owns the SRAM in RUN with no added latency on its fetches.
  assign isram_ctrl = (r_state == S_RUN) ? ctrl_isram : r_isram_ctrl;
  assign isram_din  = r_isram_din;
  assign core_rst   = r_core_rst;
  assign load_done  = r_load_done;
  assign overflow   = r_overflow;
  assign word_count = r_word_count;
  assign checksum   = r_checksum;

  // NOTE: sequential state uses non-blocking assignments only; the default
  // r_isram_ctrl assignment below is overridden by a later one in the same block.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wp         <= '0;
      r_drain      <= 1'b0;
      r_isram_ctrl <= CTRL_OFF;
      r_isram_din  <= '0;
      r_core_rst   <= 1'b1;
      r_load_done  <= 1'b0;
      r_overflow   <= 1'b0;
      r_word_count <= '0;
      r_checksum   <= '0;
    end else begin
      r_isram_ctrl <= CTRL_OFF;
      if (start) begin
        r_state      <= S_LOAD;
        r_wp         <= '0;
        r_drain      <= 1'b0;
        r_core_rst   <= 1'b1;
        r_load_done  <= 1'b0;
        r_overflow   <= 1'b0;
        r_word_count <= '0;
        r_checksum   <= '0;
      end else begin
        case (r_state)
          S_LOAD: begin
            if (r_drain) begin
              r_state     <= S_RUN;
              r_drain     <= 1'b0;
              r_core_rst  <= 1'b0;
              r_load_done <= 1'b1;
            end else if (w_hs) begin
              r_isram_ctrl <= {2'b00, 11'(r_wp[ADDR_W-1:0])};
              r_isram_din  <= host_data;
              r_checksum   <= r_checksum ^ host_data;
              r_word_count <= r_word_count + 12'd1;
              r_wp         <= r_wp + 1'b1;
              r_drain      <= host_last;
            end else if (host_valid && w_full) begin
              r_state    <= S_ERR;
              r_overflow <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: full-depth instance for load/run flows,
// a DEPTH=4 instance for the overflow path.
module tb_inst_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_start, a_valid, a_last, a_ready;
  logic [15:0] a_data;
  logic [12:0] a_ctrl_in, a_ctrl;
  logic [15:0] a_din, a_sum_o;
  logic        a_core_rst, a_done, a_ovf;
  logic [11:0] a_cnt_o;

  logic        b_start, b_valid, b_last, b_ready;
  logic [15:0] b_data;
  logic [12:0] b_ctrl_in, b_ctrl;
  logic [15:0] b_din, b_sum_o;
  logic        b_core_rst, b_done, b_ovf;
  logic [11:0] b_cnt_o;

  inst_loader dut_a (
    .clk(clk), .rst(rst), .start(a_start), .host_valid(a_valid),
    .host_data(a_data), .host_last(a_last), .host_ready(a_ready),
    .ctrl_isram(a_ctrl_in), .isram_ctrl(a_ctrl), .isram_din(a_din),
    .core_rst(a_core_rst), .load_done(a_done), .overflow(a_ovf),
    .word_count(a_cnt_o), .checksum(a_sum_o)
  );

  inst_loader #(.ADDR_W(11), .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .host_valid(b_valid),
    .host_data(b_data), .host_last(b_last), .host_ready(b_ready),
    .ctrl_isram(b_ctrl_in), .isram_ctrl(b_ctrl), .isram_din(b_din),
    .core_rst(b_core_rst), .load_done(b_done), .overflow(b_ovf),
    .word_count(b_cnt_o), .checksum(b_sum_o)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [26:0] q_a[$];
  logic [26:0] q_b[$];
  logic [26:0] e_a, e_b;
  int          a_wp, b_wp, a_cnt;
  logic [15:0] a_sum;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every SRAM write (CEN=0, WEN=0) must match the next expected {addr, data}.
  always @(negedge clk) begin
    if (a_ctrl[12:11] == 2'b00) begin
      if (q_a.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL a_write: unexpected write addr %h data %h", a_ctrl[10:0], a_din);
      end else begin
        e_a = q_a.pop_front();
        check("a_write", 32'({a_ctrl[10:0], a_din}), 32'(e_a));
      end
    end
    if (b_ctrl[12:11] == 2'b00) begin
      if (q_b.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL b_write: unexpected write addr %h data %h", b_ctrl[10:0], b_din);
      end else begin
        e_b = q_b.pop_front();
        check("b_write", 32'({b_ctrl[10:0], b_din}), 32'(e_b));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_go();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    a_wp = 0; a_sum = '0; a_cnt = 0;
  endtask

  task automatic a_send(input logic [15:0] d, input logic last);
    check("a_ready", 32'(a_ready), 32'd1);
    a_valid = 1'b1; a_data = d; a_last = last;
    q_a.push_back({11'(a_wp), d});
    a_wp++; a_cnt++; a_sum ^= d;
    step();
    a_valid = 1'b0; a_last = 1'b0;
  endtask

  task automatic b_send(input logic [15:0] d, input logic last);
    check("b_ready", 32'(b_ready), 32'd1);
    b_valid = 1'b1; b_data = d; b_last = last;
    q_b.push_back({11'(b_wp), d});
    b_wp++;
    step();
    b_valid = 1'b0; b_last = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    a_start = 0; a_valid = 0; a_last = 0; a_data = '0; a_ctrl_in = 13'h1800;
    b_start = 0; b_valid = 0; b_last = 0; b_data = '0; b_ctrl_in = 13'h1800;
    a_wp = 0; b_wp = 0; a_cnt = 0; a_sum = '0;
    step(); step();
    rst = 1'b0;

    // Reset / idle state
    @(negedge clk);
    check("rst_ctrl", 32'(a_ctrl), 32'h1800);
    check("rst_core_rst", 32'(a_core_rst), 32'd1);
    check("rst_ready", 32'(a_ready), 32'd0);
    check("rst_count", 32'(a_cnt_o), 32'd0);
    check("rst_sum", 32'(a_sum_o), 32'd0);
    check("rst_din", 32'(a_din), 32'd0);
    check("rst_flags", 32'({a_done, a_ovf}), 32'd0);

    // Back-to-back 3-word program
    step();
    a_go();
    a_send(16'h0801, 1'b0);
    a_send(16'h1234, 1'b0);
    a_send(16'h3005, 1'b1);
    @(negedge clk);
    check("drain_core_rst", 32'(a_core_rst), 32'd1);
    check("drain_ready", 32'(a_ready), 32'd0);
    step();
    @(negedge clk);
    check("run_done", 32'(a_done), 32'd1);
    check("run_core_rst", 32'(a_core_rst), 32'd0);
    check("run_count", 32'(a_cnt_o), 32'(a_cnt));
    check("run_sum", 32'(a_sum_o), 32'(a_sum));

    // RUN pass-through, host ignored
    step();
    a_ctrl_in = 13'h1005;
    a_valid = 1'b1; a_data = 16'hFFFF;
    #1;
    check("run_passthru", 32'(a_ctrl), 32'h1005);
    check("run_ready", 32'(a_ready), 32'd0);
    step();
    a_valid = 1'b0;
    a_ctrl_in = 13'h1800;
    @(negedge clk);
    check("run_count_held", 32'(a_cnt_o), 32'd3);
    check("run_sum_held", 32'(a_sum_o), 32'(a_sum));

    // start during RUN
    step();
    a_go();
    @(negedge clk);
    check("restart_core_rst", 32'(a_core_rst), 32'd1);
    check("restart_count", 32'(a_cnt_o), 32'd0);
    check("restart_done", 32'(a_done), 32'd0);

    // Gapped valid: word, idle, word, idle, ...
    step();
    for (int i = 0; i < 4; i++) begin
      a_send(16'hA000 + 16'(i), i == 3);
      if (i < 3) begin
        step();
        @(negedge clk);
        check("gap_no_write", 32'(a_ctrl[12:11]), 32'd3);
        step();
      end
    end
    step();
    @(negedge clk);
    check("gap_count", 32'(a_cnt_o), 32'd4);
    check("gap_sum", 32'(a_sum_o), 32'(a_sum));
    check("gap_done", 32'(a_done), 32'd1);

    // rst mid-LOAD after 2 words
    step();
    a_go();
    a_send(16'h5555, 1'b0);
    a_send(16'h0F0F, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_core_rst", 32'(a_core_rst), 32'd1);
    check("midrst_count", 32'(a_cnt_o), 32'd0);
    check("midrst_sum", 32'(a_sum_o), 32'd0);
    check("midrst_ready", 32'(a_ready), 32'd0);
    step();
    a_valid = 1'b1; a_data = 16'h7777;
    #1;
    check("idle_ignores_host", 32'(a_ready), 32'd0);
    step();
    a_valid = 1'b0;

    // start and rst together: rst wins
    a_start = 1'b1; rst = 1'b1;
    step();
    a_start = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("rst_wins_ready", 32'(a_ready), 32'd0);
    check("rst_wins_core_rst", 32'(a_core_rst), 32'd1);

    // DEPTH=4 overflow
    step();
    b_start = 1'b1;
    step();
    b_start = 1'b0; b_wp = 0;
    for (int i = 0; i < 4; i++) b_send(16'h1100 + 16'(i), 1'b0);
    check("full_ready", 32'(b_ready), 32'd0);
    b_valid = 1'b1; b_data = 16'hDEAD;
    step();
    b_valid = 1'b0;
    @(negedge clk);
    check("ovf_flag", 32'(b_ovf), 32'd1);
    check("ovf_core_rst", 32'(b_core_rst), 32'd1);
    check("ovf_sram_off", 32'(b_ctrl[12:11]), 32'd3);
    check("ovf_count", 32'(b_cnt_o), 32'd4);
    step();
    b_start = 1'b1;
    step();
    b_start = 1'b0; b_wp = 0;
    @(negedge clk);
    check("ovf_cleared", 32'(b_ovf), 32'd0);
    step();
    b_send(16'hBEEF, 1'b1);
    step();
    @(negedge clk);
    check("b_run_done", 32'(b_done), 32'd1);
    check("b_run_count", 32'(b_cnt_o), 32'd1);
    check("b_run_sum", 32'(b_sum_o), 32'hBEEF);

    repeat (3) step();
    check("a_queue_drained", 32'(q_a.size()), 32'd0);
    check("b_queue_drained", 32'(q_b.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
